// File: rtl/nv_ram_fifo_ctrl_pkg.sv
// nv_ram_fifo_ctrl_pkg: shared sizing constants and pointer type for the
// 80x17 RAM-backed FIFO controller.
//   FIFO_DEPTH : default RAM entry count (pointer wrap bound)
//   FIFO_WIDTH : default payload width
//   ADDR_W     : RAM address / occupancy counter width
package nv_ram_fifo_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH = 80;
    localparam int unsigned FIFO_WIDTH = 17;
    localparam int unsigned ADDR_W     = 7;

    typedef logic [ADDR_W-1:0] ptr_t;

endpackage : nv_ram_fifo_ctrl_pkg

// File: rtl/nv_ram_fifo_ctrl_ptr.sv
// nv_ram_fifo_ctrl_ptr: wrapping increment-enable pointer, 0..DEPTH-1.
// Ports:
//   clk   : clock, posedge
//   rst   : synchronous active-high reset (pointer -> 0)
//   i_inc : advance pointer this cycle
//   o_ptr : current pointer value
module nv_ram_fifo_ctrl_ptr
    import nv_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    output ptr_t o_ptr
);

    ptr_t r_ptr;
    ptr_t w_ptr_nxt;

    // Wrap at DEPTH-1 rather than at the power-of-two boundary.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (i_inc) begin
            w_ptr_nxt = (r_ptr == ptr_t'(DEPTH - 1)) ? '0 : r_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule : nv_ram_fifo_ctrl_ptr

// File: rtl/nv_ram_fifo_ctrl_80x17.sv
// nv_ram_fifo_ctrl_80x17: valid/ready FIFO controller driving an external
// two-stage RAM (read address latched on ram_re, output register loaded on
// ram_ore). Stage s1 = address in flight, stage s2 = RAM output register
// holding the head entry presented on rd_pd.
// Optional feature: define NV_RAM_FIFO_CTRL_BYPASS_EN to route a push into an
// idle FIFO straight into the RAM output register (1-cycle latency).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_pvld/wr_prdy/wr_pd    : push handshake and payload
//   rd_pvld/rd_prdy/rd_pd    : pop handshake and payload (rd_pd = ram_dout)
//   ram_wa/ram_we/ram_di     : RAM write port
//   ram_ra/ram_re/ram_ore    : RAM read address strobe / output-register load
//   ram_dout                 : RAM output register contents
//   ram_byp_sel/ram_dbyp     : RAM output-stage bypass select and data
//   ram_count                : entries in RAM not yet moved to the output reg
module nv_ram_fifo_ctrl_80x17
    import nv_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_pvld,
    output logic              wr_prdy,
    input  logic [WIDTH-1:0]  wr_pd,
    output logic              rd_pvld,
    input  logic              rd_prdy,
    output logic [WIDTH-1:0]  rd_pd,
    output logic [ADDR_W-1:0] ram_wa,
    output logic              ram_we,
    output logic [WIDTH-1:0]  ram_di,
    output logic [ADDR_W-1:0] ram_ra,
    output logic              ram_re,
    output logic              ram_ore,
    input  logic [WIDTH-1:0]  ram_dout,
    output logic              ram_byp_sel,
    output logic [WIDTH-1:0]  ram_dbyp,
    output logic [ADDR_W-1:0] ram_count
);

    logic [ADDR_W-1:0] r_count;
    logic              r_s1_vld;
    logic              r_s2_vld;

    logic [ADDR_W-1:0] w_count_nxt;
    logic              w_s1_nxt;
    logic              w_s2_nxt;
    logic              w_wr_prdy;
    logic              w_push;
    logic              w_push_ram;
    logic              w_byp;
    logic              w_adv2;
    logic              w_re;
    logic              w_ore;
    ptr_t              w_wr_ptr;
    ptr_t              w_rd_ptr;

    // Ready depends on registered occupancy only.
    assign w_wr_prdy = (r_count < ADDR_W'(DEPTH));
    assign w_push    = wr_pvld && w_wr_prdy && !rst;
    assign w_adv2    = r_s1_vld && (!r_s2_vld || rd_prdy);

`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    // Idle FIFO whose output register is free (or draining): skip the RAM.
    assign w_byp = w_push && (r_count == '0) && !r_s1_vld && (!r_s2_vld || rd_prdy);
`else
    assign w_byp = 1'b0;
`endif

    assign w_push_ram = w_push && !w_byp;
    // Entries not already in flight in s1; issue only when s1 is free or draining.
    assign w_re  = !rst && (r_count > ADDR_W'(r_s1_vld)) && (!r_s1_vld || w_adv2);
    assign w_ore = w_adv2 || w_byp;

    // Next-state: a slot is freed only when its data leaves s1 (adv2).
    always_comb begin
        w_count_nxt = r_count;
        w_s1_nxt    = r_s1_vld;
        w_s2_nxt    = r_s2_vld;
        case ({w_push_ram, w_adv2})
            2'b10:   w_count_nxt = r_count + ADDR_W'(1);
            2'b01:   w_count_nxt = r_count - ADDR_W'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_re) begin
            w_s1_nxt = 1'b1;
        end else if (w_adv2) begin
            w_s1_nxt = 1'b0;
        end
        if (w_ore) begin
            w_s2_nxt = 1'b1;
        end else if (rd_prdy) begin
            w_s2_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_s1_vld <= w_s1_nxt;
            r_s2_vld <= w_s2_nxt;
        end
    end

    nv_ram_fifo_ctrl_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push_ram),
        .o_ptr (w_wr_ptr)
    );

    nv_ram_fifo_ctrl_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_re),
        .o_ptr (w_rd_ptr)
    );

    assign wr_prdy     = w_wr_prdy;
    assign rd_pvld     = r_s2_vld;
    assign rd_pd       = ram_dout;
    assign ram_wa      = w_wr_ptr;
    assign ram_we      = w_push_ram;
    assign ram_di      = wr_pd;
    assign ram_ra      = w_rd_ptr;
    assign ram_re      = w_re;
    assign ram_ore     = w_ore;
    assign ram_byp_sel = w_byp;
    assign ram_dbyp    = w_byp ? wr_pd : '0;
    assign ram_count   = r_count;

endmodule : nv_ram_fifo_ctrl_80x17
